// File: rtl/srl_pkg.sv
// Shared constants and helpers for the SRL bus delay line and its output FIFO.
package srl_pkg;

   localparam int SRL_DEFAULT_BUS_WIDTH  = 8;
   localparam int SRL_DEFAULT_FIFO_DEPTH = 16;

   // Wide carrier for the saturating-increment helper; callers cast to their own width.
   typedef logic [31:0] srl_cnt_t;

   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic srl_cnt_t sat_inc(input srl_cnt_t v, input int width);
      srl_cnt_t lim;
      lim = (srl_cnt_t'(1) << width) - srl_cnt_t'(1);
      return (v >= lim) ? lim : v + srl_cnt_t'(1);
   endfunction

endpackage

// File: rtl/srl_fifo_mem.sv
// FIFO storage: synchronous write, asynchronous (show-ahead) read, no reset on contents.
module srl_fifo_mem #(
   parameter int BUS_WIDTH = 8,
   parameter int DEPTH     = 16,
   parameter int AW        = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [AW-1:0]        waddr,
   input  logic [BUS_WIDTH-1:0] wdata,
   input  logic [AW-1:0]        raddr,
   output logic [BUS_WIDTH-1:0] rdata
);

   logic [BUS_WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) r_mem[waddr] <= wdata;
   end

   assign rdata = r_mem[raddr];

endmodule

// File: rtl/srl_bus_fifo.sv
// Absorbs the non-stallable delay-line output into a FIFO with valid/ready drain, drop counting
// and a sticky overflow flag. Define SRL_BUS_FIFO_HWM_EN to add the high_water output.
module srl_bus_fifo
   import srl_pkg::*;
#(
   parameter int BUS_WIDTH      = SRL_DEFAULT_BUS_WIDTH,
   parameter int DEPTH          = SRL_DEFAULT_FIFO_DEPTH,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   input  logic [BUS_WIDTH-1:0]          in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BUS_WIDTH-1:0]          out_data,
   output logic [ptr_width(DEPTH)-1:0]   fill_level,
`ifdef SRL_BUS_FIFO_HWM_EN
   output logic [ptr_width(DEPTH)-1:0]   high_water,
`endif
   output logic                          overflow,
   output logic [DROP_CNT_WIDTH-1:0]     drop_count,
   input  logic                          clear_overflow
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0]             r_wr, r_rd, r_fill;
   logic                      r_ovf;
   logic [DROP_CNT_WIDTH-1:0] r_drop;

   logic                      w_empty, w_full, w_rd, w_wr, w_drop;
   logic [PW-1:0]             w_wr_nxt, w_rd_nxt, w_fill_nxt;
   logic [DROP_CNT_WIDTH-1:0] w_drop_inc;

   // MSB is the wrap bit: same address with differing wrap bits means full.
   assign w_empty = (r_wr == r_rd);
   assign w_full  = (r_wr[AW-1:0] == r_rd[AW-1:0]) && (r_wr[AW] != r_rd[AW]);

   assign w_rd   = !w_empty && out_ready;
   assign w_wr   = in_valid && (!w_full || w_rd);
   assign w_drop = in_valid && w_full && !w_rd;

   assign w_wr_nxt   = r_wr + PW'(w_wr);
   assign w_rd_nxt   = r_rd + PW'(w_rd);
   assign w_fill_nxt = w_wr_nxt - w_rd_nxt;
   assign w_drop_inc = DROP_CNT_WIDTH'(sat_inc(srl_cnt_t'(r_drop), DROP_CNT_WIDTH));

   srl_fifo_mem #(
      .BUS_WIDTH (BUS_WIDTH),
      .DEPTH     (DEPTH),
      .AW        (AW)
   ) u_mem (
      .clk   (clk),
      .we    (w_wr),
      .waddr (r_wr[AW-1:0]),
      .wdata (in_data),
      .raddr (r_rd[AW-1:0]),
      .rdata (out_data)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr   <= '0;
         r_rd   <= '0;
         r_fill <= '0;
      end else begin
         r_wr   <= w_wr_nxt;
         r_rd   <= w_rd_nxt;
         r_fill <= w_fill_nxt;
      end
   end

   // A drop in the same cycle as a clear wins, leaving a count of one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end else if (w_drop) begin
         r_ovf  <= 1'b1;
         r_drop <= clear_overflow ? DROP_CNT_WIDTH'(1) : w_drop_inc;
      end else if (clear_overflow) begin
         r_ovf  <= 1'b0;
         r_drop <= '0;
      end
   end

`ifdef SRL_BUS_FIFO_HWM_EN
   logic [PW-1:0] r_hwm;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                      r_hwm <= '0;
      else if (clear_overflow)      r_hwm <= r_fill;
      else if (w_fill_nxt > r_hwm)  r_hwm <= w_fill_nxt;
   end

   assign high_water = r_hwm;
`endif

   assign out_valid  = !w_empty;
   assign fill_level = r_fill;
   assign overflow   = r_ovf;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_srl_bus_fifo.sv
// Randomized + directed bench for srl_bus_fifo against a queue-based behavioural model.
module tb_srl_bus_fifo;

   localparam int BW  = 8;
   localparam int DEP = 16;
   localparam int DCW = 8;
   localparam int PW  = $clog2(DEP) + 1;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           in_valid = 1'b0;
   logic [BW-1:0]  in_data = '0;
   logic           out_valid;
   logic           out_ready = 1'b0;
   logic [BW-1:0]  out_data;
   logic [PW-1:0]  fill_level;
   logic           overflow;
   logic [DCW-1:0] drop_count;
   logic           clear_overflow = 1'b0;
`ifdef SRL_BUS_FIFO_HWM_EN
   logic [PW-1:0]  high_water;
`endif

   int tests = 0;
   int fails = 0;

   srl_bus_fifo #(.BUS_WIDTH(BW), .DEPTH(DEP), .DROP_CNT_WIDTH(DCW)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_data        (in_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_data       (out_data),
      .fill_level     (fill_level),
`ifdef SRL_BUS_FIFO_HWM_EN
      .high_water     (high_water),
`endif
      .overflow       (overflow),
      .drop_count     (drop_count),
      .clear_overflow (clear_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [BW-1:0] mq[$];
   bit            m_ovf = 0;
   int            m_dc  = 0;
   int            m_hwm = 0;

   // Compare on each falling edge, then advance the model with the inputs the next rising edge sees.
   always @(negedge clk) begin
      if (rst) begin
         mq.delete();
         m_ovf = 0; m_dc = 0; m_hwm = 0;
         check("rst_valid", int'(out_valid), 0);
         check("rst_fill", int'(fill_level), 0);
      end else begin
         bit rd, full, drop;
         int old_sz;
         check("m_valid", int'(out_valid), int'(mq.size() > 0));
         if (mq.size() > 0) check("m_data", int'(out_data), int'(mq[0]));
         check("m_fill", int'(fill_level), mq.size());
         check("m_ovf", int'(overflow), int'(m_ovf));
         check("m_drop", int'(drop_count), m_dc);
`ifdef SRL_BUS_FIFO_HWM_EN
         check("m_hwm", int'(high_water), m_hwm);
`endif
         old_sz = mq.size();
         rd   = (mq.size() > 0) && out_ready;
         full = (mq.size() == DEP);
         drop = in_valid && full && !rd;
         if (rd) void'(mq.pop_front());
         if (in_valid && !drop) mq.push_back(in_data);
         if (drop) begin
            m_ovf = 1;
            m_dc  = clear_overflow ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
         end else if (clear_overflow) begin
            m_ovf = 0; m_dc = 0;
         end
         if (clear_overflow) m_hwm = old_sz;
         else if (mq.size() > m_hwm) m_hwm = mq.size();
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic drive(input bit v, input logic [BW-1:0] d, input bit rdy, input bit clr);
      in_valid = v; in_data = d; out_ready = rdy; clear_overflow = clr;
   endtask

   task automatic drain();
      drive(0, 0, 1, 0);
      for (int i = 0; i < 40 && fill_level != 0; i++) step();
      check("drain_empty", int'(fill_level), 0);
   endtask

   initial begin
      step(); step();
      @(negedge clk);
      check("reset_valid", int'(out_valid), 0);
      check("reset_ovf", int'(overflow), 0);
      check("reset_drop", int'(drop_count), 0);
      step(); rst = 1'b0;

      // single word latency
      step();
      drive(1, 8'hA5, 1, 0);
      step();
      drive(0, 0, 1, 0);
      @(negedge clk);
      check("lat_valid1", int'(out_valid), 1);
      check("lat_data1", int'(out_data), 8'hA5);
      step();
      @(negedge clk);
      check("lat_valid2", int'(out_valid), 0);
      check("lat_fill2", int'(fill_level), 0);

      // overfill: 20 words, 4 dropped, first 16 read back in order
      step();
      for (int i = 0; i < 20; i++) begin drive(1, BW'(i), 0, 0); step(); end
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("ovf_fill", int'(fill_level), 16);
      check("ovf_flag", int'(overflow), 1);
      check("ovf_drop", int'(drop_count), 4);
      step();
      drive(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("ovf_order", int'(out_data), i);
         step();
      end
      @(negedge clk);
      check("ovf_empty", int'(out_valid), 0);

      // full with simultaneous read/write across pointer wrap
      step();
      drive(0, 0, 0, 1); step();
      for (int i = 0; i < 16; i++) begin drive(1, BW'(8'h40 + i), 0, 0); step(); end
      for (int i = 0; i < 10; i++) begin
         drive(1, BW'(8'h80 + i), 1, 0);
         @(negedge clk);
         check("rw_fill", int'(fill_level), 16);
         check("rw_head", int'(out_data), 8'h40 + i);
         step();
      end
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("rw_nodrop", int'(drop_count), 0);
      step();
      drain();

      // saturation and clear priority
      for (int i = 0; i < 16 + 300; i++) begin drive(1, BW'(i), 0, 0); step(); end
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("sat_drop", int'(drop_count), 8'hFF);
      step();
      drive(0, 0, 0, 1); step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("clr_ovf", int'(overflow), 0);
      check("clr_drop", int'(drop_count), 0);
      step();
      drive(1, 8'h11, 0, 1); step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("clrdrop_ovf", int'(overflow), 1);
      check("clrdrop_cnt", int'(drop_count), 1);
      step();
      drain();

      // asynchronous reset mid-operation
      for (int i = 0; i < 5; i++) begin drive(1, BW'(8'h50 + i), 0, 0); step(); end
      drive(0, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", int'(out_valid), 0);
      check("arst_fill", int'(fill_level), 0);
      step(); step();
      rst = 1'b0;
      step();
      drive(1, 8'h3C, 0, 0); step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("arst_first", int'(out_data), 8'h3C);
      check("arst_fill1", int'(fill_level), 1);
      step();
      drain();

`ifdef SRL_BUS_FIFO_HWM_EN
      drive(0, 0, 0, 1); step();
      for (int i = 0; i < 9; i++) begin drive(1, BW'(i), 0, 0); step(); end
      drive(0, 0, 1, 0);
      for (int i = 0; i < 7; i++) step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("hwm_peak", int'(high_water), 9);
      check("hwm_fill", int'(fill_level), 2);
      step();
      drive(0, 0, 0, 1); step();
      drive(0, 0, 0, 0);
      @(negedge clk);
      check("hwm_clr", int'(high_water), 2);
      step();
      drain();
`endif

      // random traffic, checked every cycle by the model
      for (int i = 0; i < 3000; i++) begin
         drive(bit'($urandom_range(0, 99) < 60), BW'($urandom_range(0, 255)),
               bit'($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 70)),
               bit'($urandom_range(0, 99) < 2));
         step();
      end
      drive(0, 0, 0, 0);
      step(); step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/srl_bus_fifo.md
Name: srl_bus_fifo

Overview:
- Downstream stage of the bus delay line (SRL_BUS).
- The delay line shifts every cycle and cannot be stalled, so this block absorbs its delayed data and valid outputs into a small FIFO.
- It presents the buffered data to the consumer through a valid/ready handshake.
- Words that arrive while the FIFO is full are dropped and counted; a sticky overflow flag records that any drop occurred.

Parameters:
- BUS_WIDTH, 8, width of each data word; must match the delay line's BUS_WIDTH.
- DEPTH, 16, number of FIFO entries; power of two, >= 2.
- DROP_CNT_WIDTH, 8, width of the saturating drop counter.

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  delayed valid from the delay line; no backpressure is possible on this side.
- in_data  input  BUS_WIDTH  delayed data word from the delay line.
- out_valid  output  1  FIFO is non-empty and out_data is valid.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_data  output  BUS_WIDTH  head-of-FIFO word (show-ahead).
- fill_level  output  $clog2(DEPTH)+1  current number of stored words, range 0..DEPTH.
- overflow  output  1  sticky flag; set on any drop.
- drop_count  output  DROP_CNT_WIDTH  saturating count of dropped words.
- clear_overflow  input  1  single-cycle pulse; clears overflow and drop_count.

Behaviour:
- Reset (asynchronous, active-high):
  - wr_ptr, rd_ptr, fill_level, overflow and drop_count go to 0; out_valid=0.
  - out_data is don't-care while out_valid=0.
  - Memory contents are not reset.
- Pointers are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = (address bits equal) and (MSBs differ).
  - Pointers wrap modulo 2*DEPTH with no special case.
- Read event: rd = out_valid & out_ready. rd_ptr increments on rd.
- Write acceptance: wr = in_valid & (!full | rd).
  - A write into a full FIFO is accepted when a read happens in the same cycle.
- Drop: drop = in_valid & full & !rd.
  - The word is discarded and no pointer moves.
  - overflow is set.
  - drop_count increments and saturates at all-ones.
- Latency:
  - A word written in cycle N (FIFO empty) gives out_valid=1 with that word on out_data in cycle N+1.
  - out_data is an asynchronous read of mem[rd_ptr], so it is show-ahead.
- Simultaneous read and write when non-empty: fill_level is unchanged.
- Simultaneous read and write when empty: only the write takes effect (out_valid is 0, so no read occurs).
- fill_level is registered and equals wr_ptr - rd_ptr after each edge.
- clear_overflow:
  - Clears overflow and drop_count on the next edge.
  - If a drop occurs in the same cycle, the drop wins: overflow=1, drop_count=1.
- Reset mid-operation: all buffered words are lost. out_valid drops to 0 asynchronously.
- out_data is stable while out_valid=1 and out_ready=0. The head entry is never overwritten, because the FIFO refuses writes when full.

Optional Feature:
- Macro: SRL_BUS_FIFO_HWM_EN.
- Defined:
  - Adds output high_water [$clog2(DEPTH)+1], the maximum fill_level observed since reset or since the last clear_overflow.
  - high_water updates on the edge where fill_level exceeds it.
  - Reset value is 0. clear_overflow loads it with the current fill_level.
- Not defined: the port and its register do not exist; behaviour is otherwise identical.

Decomposition:
- Package srl_pkg holds:
  - Function ptr_width(depth), returning $clog2(depth)+1.
  - Constants SRL_DEFAULT_BUS_WIDTH=8 and SRL_DEFAULT_FIFO_DEPTH=16.
  - Typedef for the drop counter's saturating-increment helper.
- One sub-module, srl_fifo_mem:
  - Parameterized register array (BUS_WIDTH x DEPTH).
  - Synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
  - No reset on storage.
- Pointer, flag and counter logic stays in srl_bus_fifo.

Test Plan:
- After reset, out_ready=1, single word 0xA5 with in_valid in cycle 0: out_valid=1 and out_data=0xA5 in cycle 1, out_valid=0 in cycle 2, fill_level back to 0.
- out_ready=0, DEPTH=16, write 20 consecutive words 0x00..0x13: fill_level=16 and overflow=1. drop_count=4, first 16 words read back in order 0x00..0x0F, words 0x10..0x13 lost.
- FIFO full, in_valid=1 and out_ready=1 for 10 cycles: no drops, fill_level stays 16, output order preserved across pointer wrap.
- DROP_CNT_WIDTH=8, 300 drops: drop_count saturates at 0xFF. Then clear_overflow pulse with no drop: overflow=0, drop_count=0. Then clear_overflow in the same cycle as a drop: overflow=1, drop_count=1.
- Fill to 5 entries, assert rst mid-cycle: out_valid=0 and fill_level=0 immediately. After release, the next written word 0x3C appears first on out_data.
- With SRL_BUS_FIFO_HWM_EN: fill to 9, drain to 2, high_water=9. clear_overflow then gives high_water=2.
